systolic_result_drain: RTL and testbench

- Downstream consumer of the systolic array's result interface (result_valid / result_data / result_ready).
- Accepts one output row (ARRAY_SIZE x ACC_WIDTH) per handshake and writes it to the output/accumulator SRAM at base + row index.
- Optional accumulate mode does a read-modify-write so partial sums from successive K-tiles add into the same buffer.
- Controlled by the tile sequencer with start/busy/done.

---
 rtl/systolic_result_drain_pkg.sv | 30 +++
 rtl/systolic_result_drain_if.sv | 39 +++
 rtl/systolic_result_drain_row_adder.sv | 26 ++
 rtl/systolic_result_drain.sv | 137 +++++++++++++
 tb/tb_systolic_result_drain.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_result_drain_pkg.sv
//------------------------------------------------------------------------------
// Module : systolic_result_drain_pkg
// Brief  : Shared types, row width and lane-slice helper for the result drain.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package systolic_result_drain_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int ROW_W          = DEF_ARRAY_SIZE * DEF_ACC_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RES = 3'd1,
    ST_RD_REQ   = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_WR_REQ   = 3'd4,
    ST_DONE     = 3'd5
  } drain_state_e;

  function automatic logic [DEF_ACC_WIDTH-1:0] row_lane(input logic [ROW_W-1:0] row,
                                                       input int unsigned    lane);
    return row[lane*DEF_ACC_WIDTH +: DEF_ACC_WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_result_drain_if.sv
//------------------------------------------------------------------------------
// Module : systolic_result_drain_if
// Brief  : Result-row handshake plus output SRAM request bus.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_result_drain_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int ROW_BITS = ARRAY_SIZE * ACC_WIDTH;

  logic                  result_valid;
  logic [ROW_BITS-1:0]   result_data;
  logic                  result_ready;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ROW_BITS-1:0]   mem_wdata;
  logic                  mem_gnt;
  logic [ROW_BITS-1:0]   mem_rdata;

  // master = the drain engine, slave = array source plus SRAM
  modport master (
    input  result_valid, result_data, mem_gnt, mem_rdata,
    output result_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output result_valid, result_data, mem_gnt, mem_rdata,
    input  result_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/systolic_result_drain_row_adder.sv
//------------------------------------------------------------------------------
// Module : row_adder
// Brief  : Lane-wise wrap-around adder for one result row.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module row_adder #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] a,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] b,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0] sum
);

  generate
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign sum[gi*ACC_WIDTH +: ACC_WIDTH] = a[gi*ACC_WIDTH +: ACC_WIDTH]
                                            + b[gi*ACC_WIDTH +: ACC_WIDTH];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_result_drain.sv
//------------------------------------------------------------------------------
// Module : systolic_result_drain
// Brief  : Drains result rows into the output SRAM, optionally accumulating.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [15:0]           cfg_rows,
  input  logic                  cfg_accumulate,
  output logic                  busy,
  output logic                  done,
  systolic_result_drain_if.master bus
);

  localparam int ROW_BITS = ARRAY_SIZE * ACC_WIDTH;

  drain_state_e          r_state;
  drain_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [15:0]           r_rows;
  logic                  r_acc;
  logic [15:0]           r_row;
  logic [ROW_BITS-1:0]   r_capture;
  logic [ROW_BITS-1:0]   w_sum;
  logic [15:0]           w_row_inc;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_row_inc = r_row + 16'd1;
  // Address wraps modulo 2^ADDR_WIDTH by construction of the adder width
  assign w_addr    = r_base + ADDR_WIDTH'(r_row);

  row_adder #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_row_adder (
    .a   (r_capture),
    .b   (bus.mem_rdata),
    .sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_rows    <= '0;
      r_acc     <= 1'b0;
      r_row     <= '0;
      r_capture <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base <= cfg_base_addr;
            r_rows <= cfg_rows;
            r_acc  <= cfg_accumulate;
            r_row  <= '0;
          end
        end
        ST_WAIT_RES: begin
          if (bus.result_valid) r_capture <= bus.result_data;
        end
        ST_RD_DATA: begin
          r_capture <= w_sum;
        end
        ST_WR_REQ: begin
          if (bus.mem_gnt) r_row <= w_row_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    busy             = 1'b0;
    done             = 1'b0;
    bus.result_ready = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (cfg_rows == 16'd0) ? ST_DONE : ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        busy             = 1'b1;
        bus.result_ready = 1'b1;
        if (bus.result_valid) w_state_nxt = r_acc ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ: begin
        busy         = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_addr;
        if (bus.mem_gnt) w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        busy        = 1'b1;
        w_state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        busy          = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_addr;
        bus.mem_wdata = r_capture;
        if (bus.mem_gnt) w_state_nxt = (w_row_inc == r_rows) ? ST_DONE : ST_WAIT_RES;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
//------------------------------------------------------------------------------
// Module : tb_systolic_result_drain
// Brief  : Directed self-checking bench for the result drain.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_result_drain;
  import systolic_result_drain_pkg::*;

  localparam int AS  = 4;
  localparam int AW  = 32;
  localparam int ADW = 16;
  localparam int RB  = AS * AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_base_addr;
  logic [15:0] cfg_rows;
  logic        cfg_accumulate;
  logic        busy;
  logic        done;
  logic        gnt_en;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_result_drain_if #(.ARRAY_SIZE(AS), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

  systolic_result_drain #(.ARRAY_SIZE(AS), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_rows       (cfg_rows),
    .cfg_accumulate (cfg_accumulate),
    .busy           (busy),
    .done           (done),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  assign bus.mem_gnt = gnt_en;

  // SRAM model: preloads come from the stimulus, writes are only logged
  logic [RB-1:0] mem_model [logic [15:0]];
  logic [15:0]   wr_addr_q [$];
  logic [RB-1:0] wr_data_q [$];
  int            rd_count   = 0;
  int            req_cycles = 0;

  always @(posedge clk) begin
    if (bus.mem_req) req_cycles++;
    if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
      end else begin
        rd_count++;
        if (mem_model.exists(bus.mem_addr)) bus.mem_rdata <= mem_model[bus.mem_addr];
        else                                bus.mem_rdata <= '0;
      end
    end
  end

  function automatic logic [RB-1:0] mkrow(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic do_start(input logic [15:0] base, input logic [15:0] rows, input logic acc);
    @(negedge clk);
    cfg_base_addr = base; cfg_rows = rows; cfg_accumulate = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_row(input logic [RB-1:0] d, input string name);
    bit ok = 1'b0;
    bus.result_valid = 1'b1;
    bus.result_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.result_ready) begin
        @(posedge clk); #1; ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.result_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_handshake: ready seen=0, required=1", name); end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s_done: done seen=0, required=1", name); end
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
    n_checks++; if (bus.result_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", bus.result_ready); end
    n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin n_fail++; $display("FAIL rst_req_we: got %b, required 00", {bus.mem_req, bus.mem_we}); end
    n_checks++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h, required 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== '0)   begin n_fail++; $display("FAIL rst_wdata: got %h, required 0", bus.mem_wdata); end
  endtask

  task automatic test_overwrite();
    int w0 = wr_addr_q.size();
    gnt_en = 1'b1;
    do_start(16'h0010, 16'd2, 1'b0);
    send_row(mkrow(3, 5, 0, 0), "ovw_r0");
    send_row(mkrow(6, 10, 0, 0), "ovw_r1");
    @(negedge clk);
    n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 16'h0011) begin
      n_fail++; $display("FAIL ovw_wr1_req: got req/we=%b addr=%h, required 11 0011", {bus.mem_req, bus.mem_we}, bus.mem_addr); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovw_done_pulse: got done=%b busy=%b, required 1 0", done, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ovw_done_once: got %b, required 0", done); end
    n_checks++;
    if (wr_addr_q.size() != w0 + 2) begin
      n_fail++; $display("FAIL ovw_wr_count: got %0d, required 2", wr_addr_q.size() - w0);
    end else if (wr_addr_q[w0] !== 16'h0010 || wr_data_q[w0] !== mkrow(3, 5, 0, 0) ||
                 wr_addr_q[w0+1] !== 16'h0011 || wr_data_q[w0+1] !== mkrow(6, 10, 0, 0)) begin
      n_fail++; $display("FAIL ovw_wr_data: got %h=%h %h=%h, required 0010/0011 rows [3,5,0,0] [6,10,0,0]",
                         wr_addr_q[w0], wr_data_q[w0], wr_addr_q[w0+1], wr_data_q[w0+1]);
    end
  endtask

  task automatic test_accumulate();
    int  w0 = wr_addr_q.size();
    int  r0 = rd_count;
    bit  bad_ready = 1'b0;
    bit  seen = 1'b0;
    mem_model[16'h0020] = mkrow(1, 2, 3, 4);
    do_start(16'h0020, 16'd1, 1'b1);
    send_row(mkrow(10, 20, 30, 40), "acc");
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (bus.result_ready !== 1'b0) bad_ready = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL acc_done: seen=0, required 1"); end
    n_checks++; if (bad_ready) begin n_fail++; $display("FAIL acc_ready_low: ready rose=1, required 0"); end
    n_checks++; if (rd_count - r0 != 1) begin n_fail++; $display("FAIL acc_reads: got %0d, required 1", rd_count - r0); end
    n_checks++;
    if (wr_addr_q.size() != w0 + 1) begin
      n_fail++; $display("FAIL acc_wr_count: got %0d, required 1", wr_addr_q.size() - w0);
    end else begin
      if (wr_addr_q[w0] !== 16'h0020 || wr_data_q[w0] !== mkrow(11, 22, 33, 44)) begin
        n_fail++; $display("FAIL acc_wr_data: got %h=%h, required 0020=[11,22,33,44]", wr_addr_q[w0], wr_data_q[w0]);
      end
      n_checks++;
      if (row_lane(wr_data_q[w0], 2) !== 32'd33) begin
        n_fail++; $display("FAIL acc_lane2: got %0d, required 33", row_lane(wr_data_q[w0], 2));
      end
    end
  endtask

  task automatic test_wrap_backpressure();
    int            w0 = wr_addr_q.size();
    bit            found = 1'b0;
    bit            stable_bad = 1'b0;
    logic [15:0]   a0;
    logic [RB-1:0] d0;
    mem_model[16'hFFFF] = mkrow(1, 2, 0, 0);
    mem_model[16'h0000] = mkrow(1, 1, 1, 1);
    gnt_en = 1'b1;
    do_start(16'hFFFF, 16'd2, 1'b1);
    send_row(mkrow(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 5), "wrap_r0");
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) found = 1'b1;
    end
    gnt_en = 1'b0;
    a0 = bus.mem_addr;
    d0 = bus.mem_wdata;
    n_checks++; if (!found) begin n_fail++; $display("FAIL wrap_wr_req: seen=0, required 1"); end
    n_checks++; if (a0 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h, required ffff", a0); end
    n_checks++; if (d0 !== mkrow(32'h8000_0000, 32'h1, 0, 5)) begin
      n_fail++; $display("FAIL wrap_sum: got %h, required [80000000,1,0,5]", d0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== a0 ||
          bus.mem_wdata !== d0 || bus.result_ready !== 1'b0) stable_bad = 1'b1;
    end
    n_checks++; if (stable_bad) begin n_fail++; $display("FAIL bp_stable: changed=1, required 0"); end
    n_checks++; if (wr_addr_q.size() != w0) begin n_fail++; $display("FAIL bp_no_write: got %0d, required 0", wr_addr_q.size() - w0); end
    gnt_en = 1'b1;
    send_row(mkrow(7, 8, 9, 10), "wrap_r1");
    wait_done("wrap");
    n_checks++;
    if (wr_addr_q.size() != w0 + 2) begin
      n_fail++; $display("FAIL wrap_wr_count: got %0d, required 2", wr_addr_q.size() - w0);
    end else if (wr_addr_q[w0+1] !== 16'h0000 || wr_data_q[w0+1] !== mkrow(8, 9, 10, 11)) begin
      n_fail++; $display("FAIL wrap_addr1: got %h=%h, required 0000=[8,9,10,11]", wr_addr_q[w0+1], wr_data_q[w0+1]);
    end
  endtask

  task automatic test_rows_zero();
    int q0 = req_cycles;
    do_start(16'h0030, 16'd0, 1'b0);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b busy=%b, required 1 0", done, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_once: got %b, required 0", done); end
    @(negedge clk);
    n_checks++; if (req_cycles != q0) begin n_fail++; $display("FAIL zero_no_req: got %0d, required 0", req_cycles - q0); end
  endtask

  task automatic test_busy_start_and_idle_valid();
    int w0 = wr_addr_q.size();
    bit ready_bad = 1'b0;
    do_start(16'h0040, 16'd1, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b, required 1", busy); end
    cfg_base_addr = 16'h0050; cfg_rows = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_row(mkrow(9, 9, 9, 9), "busy");
    wait_done("busy");
    @(negedge clk);
    bus.result_valid = 1'b1;
    bus.result_data  = mkrow(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.result_ready !== 1'b0) ready_bad = 1'b1;
    end
    bus.result_valid = 1'b0;
    n_checks++; if (ready_bad) begin n_fail++; $display("FAIL idle_ready: got 1, required 0"); end
    n_checks++;
    if (wr_addr_q.size() != w0 + 1) begin
      n_fail++; $display("FAIL busy_ignore_count: got %0d, required 1", wr_addr_q.size() - w0);
    end else if (wr_addr_q[w0] !== 16'h0040) begin
      n_fail++; $display("FAIL busy_ignore_addr: got %h, required 0040", wr_addr_q[w0]);
    end
  endtask

  task automatic test_reset_midop();
    int w0;
    logic [RB-1:0] exp_row;
    do_start(16'h0060, 16'd1, 1'b0);
    gnt_en = 1'b0;
    send_row(mkrow(2, 2, 2, 2), "rmid");
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_pre: got %b, required 1", bus.mem_req); end
    w0 = wr_addr_q.size();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort: got req=%b busy=%b, required 0 0", bus.mem_req, busy); end
    @(negedge clk);
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_addr_q.size() != w0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_quiet: got writes=%0d req=%b, required 0 0", wr_addr_q.size() - w0, bus.mem_req); end
    do_start(16'h0000, 16'd4, 1'b0);
    for (int r = 0; r < 4; r++) send_row(mkrow(4*r+1, 4*r+2, 4*r+3, 4*r+4), "rmid_job");
    wait_done("rmid");
    n_checks++;
    if (wr_addr_q.size() != w0 + 4) begin
      n_fail++; $display("FAIL rmid_wr_count: got %0d, required 4", wr_addr_q.size() - w0);
    end else begin
      for (int r = 0; r < 4; r++) begin
        exp_row = mkrow(4*r+1, 4*r+2, 4*r+3, 4*r+4);
        n_checks++;
        if (wr_addr_q[w0+r] !== 16'(r) || wr_data_q[w0+r] !== exp_row) begin
          n_fail++; $display("FAIL rmid_row%0d: got %h=%h, required %h=%h", r, wr_addr_q[w0+r], wr_data_q[w0+r], 16'(r), exp_row);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_base_addr = '0; cfg_rows = '0; cfg_accumulate = 1'b0;
    gnt_en = 1'b1; bus.result_valid = 1'b0; bus.result_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_overwrite();
    test_accumulate();
    test_wrap_backpressure();
    test_rows_zero();
    test_busy_start_and_idle_valid();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
